multi_finish_counter: RTL

Parametrised multi-channel event counter with a run/terminate state machine. It generalises the single free-running test counter into a reusable simulation and test-harness block. Each of CHANNELS counters counts enabled events up to LIMIT, either holding or wrapping there. The block raises `done` once every channel has reached LIMIT, or `timeout_err` if TIMEOUT cycles elapse first. It sits beside the DUT in testbench tops and small example designs, driving the end-of-test condition.

---
 rtl/multi_finish_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multi_finish_counter.sv
// Multi-channel event counter with an IDLE/RUN/DONE/TIMEOUT run controller.
// It signals end-of-test once every channel has reached LIMIT, or flags a timeout.
module multi_finish_counter #(
    parameter int          WIDTH    = 32,
    parameter int          CHANNELS = 2,
    parameter int unsigned LIMIT    = 3,
    parameter int          MODE     = 0,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       hit,
    output logic [WIDTH-1:0]          cycles,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] TMO_LAST = WIDTH'(TIMEOUT - 1);
    localparam bit               TMO_EN   = (TIMEOUT != 0);
    localparam bit               WRAP     = (MODE == 1);

    if (LIMIT == 0 || (64'(LIMIT) >> WIDTH) != 64'd0) begin : g_bad_limit
        $error("multi_finish_counter: LIMIT must lie in 1 .. 2**WIDTH-1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_finish_counter: CHANNELS must be at least 1");
    end

    logic [1:0]                     state_q, state_d;
    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]            hit_q, hit_d;
    logic [WIDTH-1:0]               cycles_q, cycles_d;
    logic                           run;
    logic                           arm;

    assign run = (state_q == S_RUN);
    assign arm = start && !run;

    // Finishing beats timing out when both become true on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (&hit_q) begin
                    state_d = S_DONE;
                end else if (TMO_EN && cycles_q == TMO_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // Per channel: arm clears everything, then clr beats en; hit is sticky until re-armed.
    always_comb begin
        count_d = count_q;
        hit_d   = hit_q;
        if (arm) begin
            count_d = '0;
            hit_d   = '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clr[i]) begin
                    count_d[i] = '0;
                end else if (run && en[i]) begin
                    if (count_q[i] == LIMIT_W) begin
                        count_d[i] = WRAP ? '0 : count_q[i];
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                    end
                end
                if (run && count_d[i] == LIMIT_W) begin
                    hit_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cycles_d = cycles_q;
        if (arm) begin
            cycles_d = '0;
        end else if (run && cycles_q != '1) begin
            cycles_d = cycles_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            hit_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hit_q    <= hit_d;
            cycles_q <= cycles_d;
        end
    end

    assign count       = count_q;
    assign hit         = hit_q;
    assign cycles      = cycles_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign timeout_err = (state_q == S_TIMEOUT);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
        a_count_le_limit: assert property (@(posedge clk) disable iff (!reset_l)
            count_q[g] <= LIMIT_W);
        c_hit_rise: cover property (@(posedge clk) disable iff (!reset_l)
            $rose(hit_q[g]));
    end

    a_done_xor_timeout: assert property (@(posedge clk) disable iff (!reset_l)
        !(done && timeout_err));
    c_enter_done: cover property (@(posedge clk) disable iff (!reset_l)
        run && state_d == S_DONE);
    c_enter_timeout: cover property (@(posedge clk) disable iff (!reset_l)
        run && state_d == S_TIMEOUT);

endmodule
